// File: rtl/port_out_uart_tx.sv
// Byte-wide output port feeding a FIFO-buffered UART 8N1 transmitter for the MIPS core.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module port_out_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int COUNT_WIDTH  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   WriteEnable,
  input  logic [7:0]             WriteData,
  output logic                   TxSerial,
  output logic                   Full,
  output logic                   Empty,
  output logic                   Busy,
  output logic                   Overflow,
  output logic [COUNT_WIDTH-1:0] FifoCount
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t                 r_state;
  state_t                 w_state_next;
  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic [BAUD_W-1:0]      r_baud;
  logic [BAUD_W-1:0]      w_baud_next;
  logic [2:0]             r_bit;
  logic [2:0]             w_bit_next;
  logic [7:0]             r_shift;
  logic [7:0]             w_shift_next;
  logic                   r_tx;
  logic                   w_tx_next;
  logic                   r_overflow;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_full;
  logic                   w_not_empty;
  logic                   w_baud_wrap;
  logic [7:0]             w_head;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity;
`endif

  assign w_full      = (r_count == COUNT_WIDTH'(FIFO_DEPTH));
  assign w_not_empty = (r_count != {COUNT_WIDTH{1'b0}});
  assign w_baud_wrap = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_head      = r_mem[r_rd_ptr];

  assign TxSerial  = r_tx;
  assign Full      = w_full;
  assign Empty     = ~w_not_empty;
  assign Busy      = (r_state != S_IDLE);
  assign Overflow  = r_overflow;
  assign FifoCount = r_count;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a pop happens only when a frame is about to start
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        if (w_baud_wrap) w_state_next = S_DATA;
        else             w_state_next = S_START;
      end
      S_DATA: begin
        if (w_baud_wrap && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end else begin
          w_state_next = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_wrap) w_state_next = S_STOP;
        else             w_state_next = S_PARITY;
      end
`endif
      S_STOP: begin
        if (w_baud_wrap && w_not_empty) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end else if (w_baud_wrap) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_STOP;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_pop        = 1'b0;
      end
    endcase
  end

  // Output logic: line level for the upcoming state, registered below
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_IDLE:   w_tx_next = 1'b1;
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      S_STOP:   w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Datapath next values; a push into a full FIFO is legal only alongside a pop
  always_comb begin
    w_push = WriteEnable & (~w_full | w_pop);
    if (w_pop || (r_state == S_IDLE)) begin
      w_baud_next = {BAUD_W{1'b0}};
    end else if (w_baud_wrap) begin
      w_baud_next = {BAUD_W{1'b0}};
    end else begin
      w_baud_next = r_baud + BAUD_W'(1);
    end
    if (r_state == S_START) begin
      w_bit_next = 3'd0;
    end else if ((r_state == S_DATA) && w_baud_wrap) begin
      w_bit_next = r_bit + 3'd1;
    end else begin
      w_bit_next = r_bit;
    end
    if (w_pop) begin
      w_shift_next = w_head;
    end else if ((r_state == S_DATA) && w_baud_wrap) begin
      w_shift_next = {1'b0, r_shift[7:1]};
    end else begin
      w_shift_next = r_shift;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + COUNT_WIDTH'(1);
      2'b01:   w_count_next = r_count - COUNT_WIDTH'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {COUNT_WIDTH{1'b0}};
      r_baud     <= {BAUD_W{1'b0}};
      r_bit      <= 3'd0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_baud     <= w_baud_next;
      r_bit      <= w_bit_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_overflow <= r_overflow | (WriteEnable & ~w_push);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the byte being framed, captured as it leaves the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= even_parity(w_head);
    end
  end
`endif

  // FIFO storage; contents are meaningless once the pointers are cleared
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= WriteData;
    end
  end

endmodule

// File: tb/tb_port_out_uart_tx.sv
// Scoreboard bench for port_out_uart_tx: a UART decoder monitor checks every frame against queued bytes.
module tb_port_out_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = CPB * NBITS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       WriteEnable = 1'b0;
  logic [7:0] WriteData = 8'd0;
  logic       TxSerial, Full, Empty, Busy, Overflow;
  logic [4:0] FifoCount;

  port_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .COUNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .WriteEnable(WriteEnable), .WriteData(WriteData),
    .TxSerial(TxSerial), .Full(Full), .Empty(Empty), .Busy(Busy),
    .Overflow(Overflow), .FifoCount(FifoCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decode frames at mid-bit and compare against the scoreboard queue
  initial forever begin
    @(negedge clk);
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (TxSerial === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_byte   = 8'd0;
        start_q.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB / 2) chk("start_bit", 32'(TxSerial), 32'd0);
      if (rx_cnt >= CPB + CPB / 2 && rx_cnt < 9 * CPB && (rx_cnt - CPB - CPB / 2) % CPB == 0)
        rx_byte[(rx_cnt - CPB - CPB / 2) / CPB] = TxSerial;
`ifdef UART_TX_PARITY_EN
      if (rx_cnt == 9 * CPB + CPB / 2) chk("parity_bit", 32'(TxSerial), 32'(^rx_byte));
`endif
      if (rx_cnt == (NBITS - 1) * CPB + CPB / 2) chk("stop_bit", 32'(TxSerial), 32'd1);
      if (rx_cnt == FRAME - 1) begin
        rx_active = 1'b0;
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic write_byte(input logic [7:0] b, output int k);
    WriteEnable = 1'b1;
    WriteData   = b;
    @(negedge clk);
    k           = cyc;
    WriteEnable = 1'b0;
    WriteData   = ~b;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rx_active || Busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(n < max_cyc), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic single_byte(input logic [7:0] b, input string name);
    int k;
    start_q.delete();
    exp_q.push_back(b);
    write_byte(b, k);
    chk({name, "_count_after_write"}, 32'(FifoCount), 32'd1);
    @(negedge clk);
    chk({name, "_empty_after_pop"}, 32'(Empty), 32'd1);
    chk({name, "_busy_at_start"}, 32'(Busy), 32'd1);
    chk({name, "_tx_low_at_start"}, 32'(TxSerial), 32'd0);
    while (cyc < k + FRAME) @(negedge clk);
    chk({name, "_busy_last_cycle"}, 32'(Busy), 32'd1);
    @(negedge clk);
    chk({name, "_busy_fall"}, 32'(Busy), 32'd0);
    wait_drain(100, name);
    chk({name, "_frames"}, 32'(start_q.size()), 32'd1);
    if (start_q.size() == 1) chk({name, "_start_latency"}, 32'(start_q[0] - k), 32'd1);
  endtask

  // Stimulus
  initial begin
    int k;
    int lows;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(TxSerial), 32'd1);
      chk("rst_empty", 32'(Empty), 32'd1);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_count", 32'(FifoCount), 32'd0);
      chk("rst_full", 32'(Full), 32'd0);
      chk("rst_ovf", 32'(Overflow), 32'd0);
    end

    single_byte(8'hA5, "single_a5");
`ifdef UART_TX_PARITY_EN
    single_byte(8'h07, "parity_07");
`endif

    start_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    WriteEnable = 1'b1;
    WriteData   = 8'h01;
    @(negedge clk);
    k = cyc;
    WriteData = 8'h02;
    @(negedge clk);
    WriteData = 8'h03;
    @(negedge clk);
    WriteEnable = 1'b0;
    wait_drain(4 * FRAME, "b2b");
    chk("b2b_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      chk("b2b_first_start", 32'(start_q[0] - k), 32'd1);
      chk("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'(FRAME));
      chk("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'(FRAME));
    end

    for (int i = 0; i < 17; i++) exp_q.push_back(8'(8'h10 + i));
    WriteEnable = 1'b1;
    for (int i = 0; i < 18; i++) begin
      WriteData = 8'(8'h10 + i);
      @(negedge clk);
    end
    WriteEnable = 1'b0;
    chk("ovf_full", 32'(Full), 32'd1);
    chk("ovf_flag", 32'(Overflow), 32'd1);
    chk("ovf_count", 32'(FifoCount), 32'd16);
    wait_drain(18 * FRAME, "ovf");
    chk("ovf_sticky", 32'(Overflow), 32'd1);
    chk("ovf_empty_end", 32'(Empty), 32'd1);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(Overflow), 32'd0);

    exp_q.push_back(8'h55);
    WriteEnable = 1'b1;
    WriteData   = 8'h55;
    @(negedge clk);
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h56 + i));
      WriteData = 8'(8'h56 + i);
      @(negedge clk);
    end
    WriteEnable = 1'b0;
    chk("mid_queued", 32'(FifoCount), 32'd4);
    while (cyc < k + 18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_tx_high", 32'(TxSerial), 32'd1);
    chk("mid_count", 32'(FifoCount), 32'd0);
    chk("mid_busy", 32'(Busy), 32'd0);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (TxSerial !== 1'b1) lows++;
    end
    chk("mid_no_frames", 32'(lows), 32'd0);
    chk("mid_empty", 32'(Empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
